// File: rtl/lif_spiking_pe_if.sv
// Port bundle for one leaky integrate-and-fire PE: enable, west/north inputs,
// timestep strobe and threshold in; forwarded values, membrane and spike out.
interface lif_spiking_pe_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24
);
    logic                     en;
    logic                     in_row;
    logic signed [DATA_W-1:0] in_col;
    logic                     step;
    logic signed [ACC_W-1:0]  thr;
    logic                     out_row;
    logic signed [DATA_W-1:0] out_col;
    logic                     out_step;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_spike;

    modport master (
        output en, in_row, in_col, step, thr,
        input  out_row, out_col, out_step, out_data, out_spike
    );

    modport slave (
        input  en, in_row, in_col, step, thr,
        output out_row, out_col, out_step, out_data, out_spike
    );
endinterface

// File: rtl/lif_spiking_pe.sv
// Leaky integrate-and-fire PE with saturating membrane and systolic forwarding.
// Optional refractory period after a spike is enabled by defining LIF_REFRACTORY_EN.
module lif_spiking_pe #(
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 24,
    parameter int LEAK_SHIFT   = 4,
    parameter int RESET_MODE   = 0,
    parameter int REFRAC_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    lif_spiking_pe_if.slave  pe
);
    typedef enum logic [0:0] {ST_INTEG = 1'b0, ST_REFRAC = 1'b1} state_t;

    localparam int CNT_W = (REFRAC_STEPS > 32'sd0) ? $clog2(REFRAC_STEPS + 32'sd1) : 32'sd1;
`ifdef LIF_REFRACTORY_EN
    localparam bit REFRAC_ON = (REFRAC_STEPS > 32'sd0);
`else
    localparam bit REFRAC_ON = 1'b0;
`endif
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(REFRAC_STEPS);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(32'd1);
    localparam logic signed [ACC_W+1:0] ACC_MAX  = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] ACC_MIN  = {3'b111, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > ACC_MAX) begin
            r = ACC_MAX[ACC_W-1:0];
        end else if (v < ACC_MIN) begin
            r = ACC_MIN[ACC_W-1:0];
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    logic                     row_r;
    logic signed [DATA_W-1:0] col_r;
    logic                     step_r;
    logic signed [ACC_W-1:0]  mem_r;
    logic                     spike_r;
    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;

    logic signed [ACC_W-1:0]  mem_nxt_s;
    logic                     spike_nxt_s;
    state_t                   state_nxt_s;
    logic [CNT_W-1:0]         cnt_nxt_s;

    logic signed [ACC_W+1:0]  weight_s;
    logic signed [ACC_W+1:0]  sum_wide_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic signed [ACC_W+1:0]  diff_wide_s;
    logic signed [ACC_W-1:0]  leak_s;

    // Two guard bits keep both the weight add and the threshold subtract exact before clamping.
    assign weight_s    = pe.in_row ? {{(ACC_W+2-DATA_W){pe.in_col[DATA_W-1]}}, pe.in_col}
                                   : {(ACC_W+2){1'b0}};
    assign sum_wide_s  = {{2{mem_r[ACC_W-1]}}, mem_r} + weight_s;
    assign sum_s       = sat_acc(sum_wide_s);
    assign diff_wide_s = {{2{sum_s[ACC_W-1]}}, sum_s} - {{2{pe.thr[ACC_W-1]}}, pe.thr};
    assign leak_s      = sum_s - (sum_s >>> LEAK_SHIFT);

    // Next-state, membrane and spike decision for the current cycle.
    always_comb begin
        mem_nxt_s   = mem_r;
        spike_nxt_s = 1'b0;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (pe.en) begin
            case (state_r)
                ST_INTEG: begin
                    if (!pe.step) begin
                        mem_nxt_s = sum_s;
                    end else if (sum_s >= $signed(pe.thr)) begin
                        spike_nxt_s = 1'b1;
                        if (RESET_MODE != 32'sd0) begin
                            mem_nxt_s = sat_acc(diff_wide_s);
                        end else begin
                            mem_nxt_s = {ACC_W{1'b0}};
                        end
                        if (REFRAC_ON) begin
                            state_nxt_s = ST_REFRAC;
                            cnt_nxt_s   = CNT_LOAD;
                        end else begin
                            state_nxt_s = ST_INTEG;
                        end
                    end else if (LEAK_SHIFT > 32'sd0) begin
                        mem_nxt_s = leak_s;
                    end else begin
                        mem_nxt_s = sum_s;
                    end
                end
                ST_REFRAC: begin
                    // Membrane is frozen; only timestep strobes advance the countdown.
                    if (pe.step) begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_nxt_s = ST_INTEG;
                        end else begin
                            state_nxt_s = ST_REFRAC;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_INTEG;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            mem_nxt_s = mem_r;
        end
    end

    // State register and refractory counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INTEG;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Forwarding registers, membrane and spike pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r   <= 1'b0;
            col_r   <= {DATA_W{1'b0}};
            step_r  <= 1'b0;
            mem_r   <= {ACC_W{1'b0}};
            spike_r <= 1'b0;
        end else begin
            if (pe.en) begin
                row_r  <= pe.in_row;
                col_r  <= pe.in_col;
                step_r <= pe.step;
            end
            mem_r   <= mem_nxt_s;
            spike_r <= spike_nxt_s;
        end
    end

    assign pe.out_row   = row_r;
    assign pe.out_col   = col_r;
    assign pe.out_step  = step_r;
    assign pe.out_data  = mem_r;
    assign pe.out_spike = spike_r;

endmodule
